// File: rtl/motion_pkg.sv
// Shared types and defaults for the motion-channel arbitration blocks.
// NOS_CLOCKS normally comes from global_constants.sv; the guard keeps this file usable on its own.
`ifndef NOS_CLOCKS
`define NOS_CLOCKS 5
`endif

package motion_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  localparam int NOS_REQ_DEFAULT  = 4;
  localparam int HOLD_MAX_DEFAULT = 15;
  localparam int PHASES_DEFAULT   = `NOS_CLOCKS;

  // Successor index modulo n; n need not be a power of two.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/phase_slot_arbiter_if.sv
// Requester-facing bundle of the phase slot arbiter.
interface phase_slot_arbiter_if
  import motion_pkg::*;
#(
  parameter int NOS_REQ = NOS_REQ_DEFAULT
) ();

  localparam int IDX_W = (NOS_REQ > 1) ? $clog2(NOS_REQ) : 1;

  logic [NOS_REQ-1:0] req;
  logic [NOS_REQ-1:0] done;
  logic [NOS_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_id;
  logic               busy;
  logic               slot_start;
  logic               timeout;
  logic               phase_err;

  // master is the arbiter side, slave is the requester / resource side.
  modport master (
    input  req, done,
    output grant, grant_id, busy, slot_start, timeout, phase_err
  );

  modport slave (
    output req, done,
    input  grant, grant_id, busy, slot_start, timeout, phase_err
  );

endinterface

// File: rtl/phase_slot_arbiter_rr_pick.sv
// Combinational round-robin picker: first request not masked, searching upward from pointer with wrap.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] pointer,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  logic [IDX_W-1:0] cand_s;
  logic             hit_s;

  // Scan candidates in priority order; the first hit latches and later ones are ignored.
  always_comb begin
    found  = 1'b0;
    index  = {IDX_W{1'b0}};
    cand_s = pointer;
    hit_s  = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand_s = IDX_W'((int'(pointer) + i) % N);
      hit_s  = !found && req[cand_s] && !mask[cand_s];
      index  = hit_s ? cand_s : index;
      found  = found | hit_s;
    end
  end

endmodule

// File: rtl/phase_slot_arbiter.sv
// Frame-synchronous round-robin owner arbiter for a phase-sequenced shared resource.
// Ownership only moves at the edge ending the cycle where the last phase is active.
module phase_slot_arbiter
  import motion_pkg::*;
#(
  parameter int NOS_REQ  = NOS_REQ_DEFAULT,
  parameter int HOLD_MAX = HOLD_MAX_DEFAULT,
  parameter int PHASES   = PHASES_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PHASES-1:0] phi_clk,
  phase_slot_arbiter_if.master bus
);

  localparam int IDX_W = (NOS_REQ > 1) ? $clog2(NOS_REQ) : 1;
  localparam int HW    = $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_MAX);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1'b1);

  arb_state_t         state_r, state_nxt_s;
  logic [IDX_W-1:0]   ptr_r, ptr_nxt_s;
  logic [HW-1:0]      hold_r, hold_nxt_s;
  logic [NOS_REQ-1:0] penalty_r, penalty_nxt_s;
  logic               release_r, release_nxt_s;
  logic [NOS_REQ-1:0] grant_r, grant_nxt_s;
  logic [IDX_W-1:0]   grant_id_r, grant_id_nxt_s;
  logic               busy_r, busy_nxt_s;
  logic               slot_start_r, slot_start_nxt_s;
  logic               timeout_r, timeout_nxt_s;
  logic               phase_err_r, phase_err_nxt_s;

  logic               eval_s, phase_ok_s, owned_s;
  logic               rel_now_s, drop_s, force_s, arb_s;
  logic [NOS_REQ-1:0] owner_bit_s, mask_s, pick_bit_s;
  logic               found_s;
  logic [IDX_W-1:0]   pick_s, arb_ptr_s;

  assign eval_s     = phi_clk[PHASES-1];
  assign phase_ok_s = $onehot(phi_clk);
  assign owned_s    = (state_r == OWNED);

  assign owner_bit_s = NOS_REQ'(1'b1) << grant_id_r;
  assign rel_now_s   = release_r | (owned_s & bus.done[grant_id_r]);
  assign drop_s      = owned_s & (rel_now_s | ~bus.req[grant_id_r]);
  // A release that lands on the hold limit is a normal release, not a timeout.
  assign force_s     = owned_s & ~drop_s & (hold_r == HOLD_LIM);
  assign arb_s       = ~owned_s | drop_s | force_s;

  // A forced-out owner is excluded from the arbitration that replaces it.
  assign mask_s     = penalty_r | (force_s ? owner_bit_s : {NOS_REQ{1'b0}});
  assign pick_bit_s = NOS_REQ'(1'b1) << pick_s;
  assign arb_ptr_s  = IDX_W'(wrap_inc(int'(pick_s), NOS_REQ));

  rr_pick #(
    .N     (NOS_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req     (bus.req),
    .mask    (mask_s),
    .pointer (ptr_r),
    .found   (found_s),
    .index   (pick_s)
  );

  // Next-state and next-output decision for the arbiter FSM.
  always_comb begin
    state_nxt_s      = state_r;
    ptr_nxt_s        = ptr_r;
    hold_nxt_s       = hold_r;
    penalty_nxt_s    = penalty_r;
    release_nxt_s    = release_r;
    grant_nxt_s      = grant_r;
    grant_id_nxt_s   = grant_id_r;
    busy_nxt_s       = busy_r;
    slot_start_nxt_s = 1'b0;
    timeout_nxt_s    = 1'b0;
    phase_err_nxt_s  = phase_err_r;

    if (!phase_ok_s || phase_err_r) begin
      phase_err_nxt_s = 1'b1;
      state_nxt_s     = IDLE;
      grant_nxt_s     = {NOS_REQ{1'b0}};
      grant_id_nxt_s  = {IDX_W{1'b0}};
      busy_nxt_s      = 1'b0;
      hold_nxt_s      = {HW{1'b0}};
      release_nxt_s   = 1'b0;
    end else if (eval_s && arb_s) begin
      state_nxt_s      = found_s ? OWNED : IDLE;
      grant_nxt_s      = found_s ? pick_bit_s : {NOS_REQ{1'b0}};
      grant_id_nxt_s   = found_s ? pick_s : {IDX_W{1'b0}};
      busy_nxt_s       = found_s;
      slot_start_nxt_s = found_s;
      hold_nxt_s       = found_s ? HOLD_ONE : {HW{1'b0}};
      ptr_nxt_s        = found_s ? arb_ptr_s : ptr_r;
      release_nxt_s    = 1'b0;
      timeout_nxt_s    = force_s;
      penalty_nxt_s    = force_s ? owner_bit_s : {NOS_REQ{1'b0}};
    end else if (eval_s) begin
      hold_nxt_s    = (hold_r == HOLD_LIM) ? hold_r : hold_r + HOLD_ONE;
      release_nxt_s = 1'b0;
    end else begin
      release_nxt_s = rel_now_s;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      ptr_r        <= {IDX_W{1'b0}};
      hold_r       <= {HW{1'b0}};
      penalty_r    <= {NOS_REQ{1'b0}};
      release_r    <= 1'b0;
      grant_r      <= {NOS_REQ{1'b0}};
      grant_id_r   <= {IDX_W{1'b0}};
      busy_r       <= 1'b0;
      slot_start_r <= 1'b0;
      timeout_r    <= 1'b0;
      phase_err_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      ptr_r        <= ptr_nxt_s;
      hold_r       <= hold_nxt_s;
      penalty_r    <= penalty_nxt_s;
      release_r    <= release_nxt_s;
      grant_r      <= grant_nxt_s;
      grant_id_r   <= grant_id_nxt_s;
      busy_r       <= busy_nxt_s;
      slot_start_r <= slot_start_nxt_s;
      timeout_r    <= timeout_nxt_s;
      phase_err_r  <= phase_err_nxt_s;
    end
  end

  assign bus.grant      = grant_r;
  assign bus.grant_id   = grant_id_r;
  assign bus.busy       = busy_r;
  assign bus.slot_start = slot_start_r;
  assign bus.timeout    = timeout_r;
  assign bus.phase_err  = phase_err_r;

endmodule

// File: tb/tb_phase_slot_arbiter.sv
// Scoreboard bench for phase_slot_arbiter: a 4-requester and a 3-requester instance on a shared 5-phase clock.
module tb_phase_slot_arbiter;
  import motion_pkg::*;

  localparam int NR  = 4;
  localparam int NR3 = 3;
  localparam int HM  = 3;
  localparam int PH  = 5;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] gid;
    logic       busy;
    logic       ss;
    logic       to;
    logic       perr;
  } obs_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [PH-1:0] phi;
  logic          bad_phase = 1'b0;
  int            ph = 0;
  int            checks = 0;
  int            errors = 0;
  obs_t          exp_q[$];
  obs_t          got, exp;

  phase_slot_arbiter_if #(.NOS_REQ(NR))  io  ();
  phase_slot_arbiter_if #(.NOS_REQ(NR3)) io3 ();

  phase_slot_arbiter #(.NOS_REQ(NR), .HOLD_MAX(HM), .PHASES(PH)) dut (
    .clk(clk), .reset(reset), .phi_clk(phi), .bus(io.master)
  );

  phase_slot_arbiter #(.NOS_REQ(NR3), .HOLD_MAX(HM), .PHASES(PH)) dut3 (
    .clk(clk), .reset(reset), .phi_clk(phi), .bus(io3.master)
  );

  initial forever #5 clk = ~clk;

  function automatic obs_t mk(input logic [3:0] g, input logic [1:0] id,
                              input logic b, input logic s, input logic t, input logic p);
    return {g, id, b, s, t, p};
  endfunction

  function automatic obs_t obs4();
    return {io.grant, io.grant_id, io.busy, io.slot_start, io.timeout, io.phase_err};
  endfunction

  function automatic obs_t obs3();
    return {1'b0, io3.grant, io3.grant_id, io3.busy, io3.slot_start, io3.timeout, io3.phase_err};
  endfunction

  // One clock: present the next phase at the falling edge, return just after the rising edge.
  task automatic cycle();
    @(negedge clk);
    phi = bad_phase ? 5'b00011 : (5'b00001 << ph);
    ph  = (ph == PH - 1) ? 0 : ph + 1;
    @(posedge clk);
    #1;
  endtask

  // Run through the next evaluation cycle; outputs are then the E+1 values.
  task automatic frame();
    int last;
    do begin
      last = ph;
      cycle();
    end while (last != PH - 1);
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    io.req   = 4'b0000;
    io.done  = 4'b0000;
    io3.req  = 3'b000;
    io3.done = 3'b000;
    cycle();
    cycle();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    io.req   = 4'b0000;
    io.done  = 4'b0000;
    io3.req  = 3'b000;
    io3.done = 3'b000;
    repeat (3) cycle();
    exp_q.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    got = obs4(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset4: got %b required %b", got, exp); end
    got = obs3(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset3: got %b required %b", got, exp); end
    reset = 1'b1;
    frame();
    got = obs4(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL idle_no_req: got %b required %b", got, exp); end
  endtask

  task automatic test_single();
    do_reset();
    frame();
    cycle();
    cycle();
    io.req = 4'b0100;
    exp_q.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(4'b0100, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(4'b0100, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    cycle();
    got = obs4(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL single_before_E: got %b required %b", got, exp); end
    frame();
    got = obs4(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL single_grant: got %b required %b", got, exp); end
    cycle();
    got = obs4(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL single_pulse_end: got %b required %b", got, exp); end
    io.req = 4'b0000;
    frame();
    got = obs4(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL single_release: got %b required %b", got, exp); end
  endtask

  task automatic test_round_robin();
    int id;
    do_reset();
    io.req = 4'b1111;
    exp_q.push_back(mk(4'b0001, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0));
    frame();
    got = obs4(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL rr[0]: got %b required %b", got, exp); end
    for (int k = 1; k <= 4; k++) begin
      id = k % NR;
      io.done = 4'b0001 << ((k - 1) % NR);
      exp_q.push_back(mk(4'b0001 << id, 2'(id), 1'b1, 1'b1, 1'b0, 1'b0));
      cycle();
      io.done = 4'b0000;
      frame();
      got = obs4(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL rr[%0d]: got %b required %b", k, got, exp); end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    io.req = 4'b0011;
    exp_q.push_back(mk(4'b0001, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(4'b0010, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0));
    exp_q.push_back(mk(4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int f = 0; f < 5; f++) begin
      frame();
      got = obs4(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL timeout_pair[%0d]: got %b required %b", f, got, exp); end
    end
    do_reset();
    io.req = 4'b0001;
    exp_q.push_back(mk(4'b0001, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(4'b0001, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0));
    for (int f = 0; f < 6; f++) begin
      frame();
      got = obs4(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL timeout_sole[%0d]: got %b required %b", f, got, exp); end
    end
  endtask

  task automatic test_done_at_limit();
    do_reset();
    io.req = 4'b0110;
    exp_q.push_back(mk(4'b0010, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(4'b0100, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0));
    for (int f = 0; f < 3; f++) begin
      frame();
      got = obs4(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL done_limit[%0d]: got %b required %b", f, got, exp); end
    end
    io.done = 4'b0010;
    cycle();
    io.done = 4'b0000;
    frame();
    got = obs4(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL done_limit_release: got %b required %b", got, exp); end
  endtask

  task automatic test_phase_err();
    do_reset();
    io.req = 4'b0001;
    exp_q.push_back(mk(4'b0001, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    frame();
    got = obs4(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL perr_grant: got %b required %b", got, exp); end
    cycle();
    bad_phase = 1'b1;
    cycle();
    bad_phase = 1'b0;
    got = obs4(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL perr_set: got %b required %b", got, exp); end
    for (int f = 0; f < 2; f++) begin
      frame();
      got = obs4(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL perr_sticky[%0d]: got %b required %b", f, got, exp); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    io.req = 4'b1000;
    exp_q.push_back(mk(4'b1000, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(4'b1000, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0));
    frame();
    got = obs4(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL arst_grant: got %b required %b", got, exp); end
    cycle();
    #2;
    reset = 1'b0;
    #1;
    got = obs4(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL arst_immediate: got %b required %b", got, exp); end
    cycle();
    reset = 1'b1;
    frame();
    got = obs4(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL arst_regrant: got %b required %b", got, exp); end
  endtask

  task automatic test_wrap3();
    int id;
    do_reset();
    io3.req = 3'b111;
    exp_q.push_back(mk(4'b0001, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0));
    frame();
    got = obs3(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL wrap3[0]: got %b required %b", got, exp); end
    for (int k = 1; k <= 4; k++) begin
      id = k % NR3;
      io3.done = 3'b001 << ((k - 1) % NR3);
      exp_q.push_back(mk(4'b0001 << id, 2'(id), 1'b1, 1'b1, 1'b0, 1'b0));
      cycle();
      io3.done = 3'b000;
      frame();
      got = obs3(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL wrap3[%0d]: got %b required %b", k, got, exp); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    phi      = 5'b00001;
    io.req   = 4'b0000;
    io.done  = 4'b0000;
    io3.req  = 3'b000;
    io3.done = 3'b000;
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_done_at_limit();
    test_phase_err();
    test_async_reset();
    test_wrap3();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
